// File: rtl/reg_window_ctrl.sv
// Register-window spill/fill controller: turns save/restore into window moves and spills/fills
// windows to a memory stack on overflow/underflow. Define WINCTRL_STATS_EN for spill/fill counters.
module reg_window_ctrl #(
    parameter int NUM_PHYS = 32,
    parameter int MAX_RES  = 7,
    parameter int CNT_W    = 12
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        save_req,
    input  logic        restore_req,
    output logic        busy,
    output logic [1:0]  winAddSub,
    output logic [4:0]  wp,
    output logic        underflow_err,
    output logic        overflow_err,
    input  logic [15:0] sp_base,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    output logic [4:0]  rf_sel,
    input  logic [15:0] rf_rdata,
    output logic [15:0] rf_wdata,
    output logic        rf_we
`ifdef WINCTRL_STATS_EN
    ,
    output logic [15:0] n_spills,
    output logic [15:0] n_fills
`endif
);

    localparam int WP_W  = $clog2(NUM_PHYS);
    localparam int RES_W = $clog2(MAX_RES + 1);

    localparam logic [WP_W-1:0]  STRIDE   = WP_W'(4);
    localparam logic [WP_W-1:0]  SEL_ONE  = WP_W'(1);
    localparam logic [RES_W-1:0] RES_ONE  = RES_W'(1);
    localparam logic [RES_W-1:0] RES_MAX  = RES_W'(MAX_RES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [1:0]       CMD_ADD  = 2'b10;
    localparam logic [1:0]       CMD_SUB  = 2'b01;
    localparam logic [1:0]       CMD_HOLD = 2'b00;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SPILL,
        S_ADV,
        S_FILL,
        S_RET
    } state_e;

    state_e           state_q;
    logic [WP_W-1:0]  wp_q;
    logic [RES_W-1:0] res_q;
    logic [CNT_W-1:0] spill_cnt_q;
    logic [1:0]       beat_q;
    logic [1:0]       win_cmd_q;
    logic             ovf_q;
    logic             unf_q;
    logic             mem_req_q;
    logic             mem_we_q;
    logic [15:0]      mem_addr_q;
    logic [WP_W-1:0]  rf_sel_q;

    logic [WP_W-1:0]  res_off_d;
    logic [WP_W-1:0]  spill_base_d;
    logic [WP_W-1:0]  fill_base_d;
    logic [CNT_W-1:0] cnt_m1_d;
    logic [15:0]      spill_addr_d;
    logic [15:0]      fill_addr_d;
    logic             last_beat_ack;

    // Oldest resident window sits (res-1) windows below the current one; its top 4 regs go out.
    always_comb begin
        res_off_d    = WP_W'(res_q - RES_ONE) << 2;
        spill_base_d = wp_q - res_off_d;
        fill_base_d  = wp_q - STRIDE;
        cnt_m1_d     = spill_cnt_q - CNT_ONE;
        spill_addr_d = sp_base + 16'({spill_cnt_q, 2'b00});
        fill_addr_d  = sp_base + 16'({cnt_m1_d, 2'b00});
    end

    assign last_beat_ack = mem_req_q && mem_ack && (beat_q == 2'd3);

    // NOTE: all state and registered outputs use non-blocking assignments so every
    // right-hand side sees the pre-edge value regardless of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            wp_q        <= '0;
            res_q       <= RES_ONE;
            spill_cnt_q <= '0;
            beat_q      <= '0;
            win_cmd_q   <= CMD_HOLD;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            rf_sel_q    <= '0;
        end else begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (save_req) begin
                        if (res_q < RES_MAX) begin
                            res_q     <= res_q + RES_ONE;
                            state_q   <= S_ADV;
                            win_cmd_q <= CMD_ADD;
                        end else if (spill_cnt_q == CNT_MAX) begin
                            ovf_q <= 1'b1;
                        end else begin
                            state_q    <= S_SPILL;
                            mem_req_q  <= 1'b1;
                            mem_we_q   <= 1'b1;
                            mem_addr_q <= spill_addr_d;
                            rf_sel_q   <= spill_base_d;
                            beat_q     <= '0;
                        end
                    end else if (restore_req) begin
                        if (res_q > RES_ONE) begin
                            res_q     <= res_q - RES_ONE;
                            state_q   <= S_RET;
                            win_cmd_q <= CMD_SUB;
                        end else if (spill_cnt_q == '0) begin
                            unf_q <= 1'b1;
                        end else begin
                            state_q    <= S_FILL;
                            mem_req_q  <= 1'b1;
                            mem_we_q   <= 1'b0;
                            mem_addr_q <= fill_addr_d;
                            rf_sel_q   <= fill_base_d;
                            beat_q     <= '0;
                        end
                    end
                end
                S_SPILL, S_FILL: begin
                    if (last_beat_ack) begin
                        mem_req_q  <= 1'b0;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= '0;
                        rf_sel_q   <= '0;
                        beat_q     <= '0;
                        if (state_q == S_SPILL) begin
                            spill_cnt_q <= spill_cnt_q + CNT_ONE;
                            state_q     <= S_ADV;
                            win_cmd_q   <= CMD_ADD;
                        end else begin
                            spill_cnt_q <= cnt_m1_d;
                            state_q     <= S_RET;
                            win_cmd_q   <= CMD_SUB;
                        end
                    end else if (mem_ack) begin
                        beat_q     <= beat_q + 2'd1;
                        mem_addr_q <= mem_addr_q + 16'd1;
                        rf_sel_q   <= rf_sel_q + SEL_ONE;
                    end
                end
                S_ADV: begin
                    wp_q      <= wp_q + STRIDE;
                    win_cmd_q <= CMD_HOLD;
                    state_q   <= S_IDLE;
                end
                S_RET: begin
                    wp_q      <= wp_q - STRIDE;
                    win_cmd_q <= CMD_HOLD;
                    state_q   <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy          = (state_q != S_IDLE);
    assign winAddSub     = win_cmd_q;
    assign wp            = wp_q;
    assign overflow_err  = ovf_q;
    assign underflow_err = unf_q;
    assign mem_req       = mem_req_q;
    assign mem_we        = mem_we_q;
    assign mem_addr      = mem_addr_q;
    assign rf_sel        = rf_sel_q;

    // Spill data and fill write-back are pass-throughs of the combinational RF read and memory data.
    assign mem_wdata = (state_q == S_SPILL) ? rf_rdata : '0;
    assign rf_we     = (state_q == S_FILL) && mem_ack;
    assign rf_wdata  = rf_we ? mem_rdata : '0;

`ifdef WINCTRL_STATS_EN
    logic [15:0] n_spills_q;
    logic [15:0] n_fills_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            n_spills_q <= '0;
            n_fills_q  <= '0;
        end else if (last_beat_ack) begin
            if (state_q == S_SPILL && n_spills_q != 16'hFFFF) begin
                n_spills_q <= n_spills_q + 16'd1;
            end
            if (state_q == S_FILL && n_fills_q != 16'hFFFF) begin
                n_fills_q <= n_fills_q + 16'd1;
            end
        end
    end

    assign n_spills = n_spills_q;
    assign n_fills  = n_fills_q;
`endif

endmodule

// File: tb/tb_reg_window_ctrl.sv
// Scoreboard bench for reg_window_ctrl: directed save/restore sequences with a register-file
// and memory model; expected window moves, memory beats and error pulses are queued up front.
module tb_reg_window_ctrl;

    typedef enum logic [1:0] {K_WIN, K_MEM, K_OVF, K_UNF} kind_e;
    typedef struct packed {
        kind_e       kind;
        logic        we;
        logic [15:0] addr;
        logic [15:0] data;
        logic [4:0]  idx;
    } ev_t;

    logic        clock;
    logic        reset;
    logic        save_req;
    logic        restore_req;
    logic        busy;
    logic [1:0]  winAddSub;
    logic [4:0]  wp;
    logic        underflow_err;
    logic        overflow_err;
    logic [15:0] sp_base;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic [4:0]  rf_sel;
    logic [15:0] rf_rdata;
    logic [15:0] rf_wdata;
    logic        rf_we;
`ifdef WINCTRL_STATS_EN
    logic [15:0] n_spills;
    logic [15:0] n_fills;
`endif

    reg_window_ctrl dut (
        .clock         (clock),
        .reset         (reset),
        .save_req      (save_req),
        .restore_req   (restore_req),
        .busy          (busy),
        .winAddSub     (winAddSub),
        .wp            (wp),
        .underflow_err (underflow_err),
        .overflow_err  (overflow_err),
        .sp_base       (sp_base),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .mem_ack       (mem_ack),
        .rf_sel        (rf_sel),
        .rf_rdata      (rf_rdata),
        .rf_wdata      (rf_wdata),
        .rf_we         (rf_we)
`ifdef WINCTRL_STATS_EN
        ,
        .n_spills      (n_spills),
        .n_fills       (n_fills)
`endif
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Physical register file model: reset pattern, optional scribble of pr0..pr7, fill writes.
    logic [15:0] pr [0:31];
    logic        scramble;
    assign rf_rdata = pr[rf_sel];

    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                pr[i] <= (i < 4) ? 16'(16'h00A0 + i) : 16'(16'hB000 + i);
            end
        end else if (scramble) begin
            for (int i = 0; i < 8; i++) pr[i] <= 16'hDEAD;
        end else if (rf_we) begin
            pr[rf_sel] <= rf_wdata;
        end
    end

    // Spill-stack memory with a programmable number of wait cycles per beat.
    logic [15:0] mem_model [0:1023];
    int          ack_delay;
    int          ack_wait;
    assign mem_ack   = mem_req && (ack_wait >= ack_delay);
    assign mem_rdata = mem_model[mem_addr[9:0]];

    always @(posedge clock) begin
        if (!mem_req || mem_ack) ack_wait <= 0;
        else                     ack_wait <= ack_wait + 1;
        if (mem_req && mem_ack && mem_we) mem_model[mem_addr[9:0]] <= mem_wdata;
    end

    int  n_pass;
    int  n_total;
    ev_t exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, wanted %0h", name, act, exp);
    endtask

    task automatic push_win(input logic [1:0] cmd, input logic [4:0] w);
        exp_q.push_back('{kind: K_WIN, we: 1'b0, addr: 16'h0, data: {14'h0, cmd}, idx: w});
    endtask

    task automatic push_mem(input logic we, input logic [15:0] a, input logic [15:0] d,
                            input logic [4:0] sel);
        exp_q.push_back('{kind: K_MEM, we: we, addr: a, data: d, idx: sel});
    endtask

    task automatic push_err(input kind_e k, input logic [4:0] w);
        exp_q.push_back('{kind: k, we: 1'b0, addr: 16'h0, data: 16'h0, idx: w});
    endtask

    // Monitor: every observable DUT action is popped against the scoreboard.
    ev_t mon_got;
    ev_t mon_exp;
    bit  mon_have;

    always @(negedge clock) begin
        if (!reset) begin
            mon_have = 1'b1;
            if (mem_req && mem_ack)
                mon_got = '{kind: K_MEM, we: mem_we, addr: mem_addr,
                            data: mem_we ? mem_wdata : (rf_we ? rf_wdata : 16'h0), idx: rf_sel};
            else if (winAddSub != 2'b00)
                mon_got = '{kind: K_WIN, we: 1'b0, addr: 16'h0, data: {14'h0, winAddSub}, idx: wp};
            else if (overflow_err)
                mon_got = '{kind: K_OVF, we: 1'b0, addr: 16'h0, data: 16'h0, idx: wp};
            else if (underflow_err)
                mon_got = '{kind: K_UNF, we: 1'b0, addr: 16'h0, data: 16'h0, idx: wp};
            else
                mon_have = 1'b0;
            if (mon_have) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL sb_unexpected: got %0h, wanted no event", mon_got);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("sb_event", 64'(mon_got), 64'(mon_exp));
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // One-cycle request pulse, then count busy cycles (bounded) until the FSM is idle again.
    task automatic op(input bit s, input bit r, input int exp_busy, input string name);
        int cnt = 0;
        save_req    = s;
        restore_req = r;
        tick(1);
        save_req    = 1'b0;
        restore_req = 1'b0;
        while (busy && cnt < 64) begin
            cnt++;
            tick(1);
        end
        check({name, "_busy_cycles"}, 64'(cnt), 64'(exp_busy));
    endtask

    logic [4:0] ret_wp [6];

    initial begin
        n_pass      = 0;
        n_total     = 0;
        reset       = 1'b1;
        save_req    = 1'b0;
        restore_req = 1'b0;
        sp_base     = 16'h0100;
        ack_delay   = 0;
        scramble    = 1'b0;
        ret_wp      = '{5'd0, 5'd28, 5'd24, 5'd20, 5'd16, 5'd12};
        tick(3);
        reset = 1'b0;
        tick(5);

        check("rst_wp", 64'(wp), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_winaddsub", 64'(winAddSub), 64'(0));
        check("rst_mem_req", 64'(mem_req), 64'(0));

        // Six plain saves (first three spaced 3 cycles), no memory traffic.
        for (int i = 0; i < 6; i++) begin
            push_win(2'b10, 5'(4 * i));
            op(1'b1, 1'b0, 1, "save");
            check("wp_after_save", 64'(wp), 64'(4 * (i + 1)));
            tick(2);
        end

        // Seventh save spills pr0..pr3 to 0x100..0x103, eighth spills pr4..pr7 and wraps wp 28->0.
        for (int k = 0; k < 4; k++) push_mem(1'b1, 16'(16'h0100 + k), 16'(16'h00A0 + k), 5'(k));
        push_win(2'b10, 5'd24);
        op(1'b1, 1'b0, 5, "spill0");
        check("wp_after_spill0", 64'(wp), 64'(28));
        for (int k = 0; k < 4; k++) push_mem(1'b1, 16'(16'h0104 + k), 16'(16'hB004 + k), 5'(4 + k));
        push_win(2'b10, 5'd28);
        op(1'b1, 1'b0, 5, "spill1");
        check("wp_wrap_up", 64'(wp), 64'(0));

        // Clobber pr0..pr7 so the fills have to restore them from memory.
        scramble = 1'b1;
        tick(1);
        scramble = 1'b0;

        // Six plain restores (first wraps 0->28), then two fills.
        for (int i = 0; i < 6; i++) begin
            push_win(2'b01, ret_wp[i]);
            op(1'b0, 1'b1, 1, "ret");
        end
        check("wp_after_rets", 64'(wp), 64'(8));
        for (int k = 0; k < 4; k++) push_mem(1'b0, 16'(16'h0104 + k), 16'(16'hB004 + k), 5'(4 + k));
        push_win(2'b01, 5'd8);
        op(1'b0, 1'b1, 5, "fill1");
        check("wp_after_fill1", 64'(wp), 64'(4));
        for (int k = 0; k < 4; k++) push_mem(1'b0, 16'(16'h0100 + k), 16'(16'h00A0 + k), 5'(k));
        push_win(2'b01, 5'd4);
        op(1'b0, 1'b1, 5, "fill0");
        check("wp_after_fill0", 64'(wp), 64'(0));
        for (int k = 0; k < 4; k++) begin
            check("pr_lo_restored", 64'(pr[k]), 64'(16'h00A0 + k));
            check("pr_hi_restored", 64'(pr[4 + k]), 64'(16'hB004 + k));
        end

        // Nothing left to restore: underflow pulse, no busy, wp untouched.
        push_err(K_UNF, 5'd0);
        restore_req = 1'b1;
        tick(1);
        restore_req = 1'b0;
        check("unf_busy", 64'(busy), 64'(0));
        check("unf_pulse", 64'(underflow_err), 64'(1));
        tick(1);
        check("unf_pulse_end", 64'(underflow_err), 64'(0));
        check("unf_wp", 64'(wp), 64'(0));

        // Simultaneous save+restore: save wins; restore held during busy is dropped.
        push_win(2'b10, 5'd0);
        save_req    = 1'b1;
        restore_req = 1'b1;
        tick(1);
        save_req = 1'b0;
        check("arb_busy", 64'(busy), 64'(1));
        tick(1);
        restore_req = 1'b0;
        check("arb_idle", 64'(busy), 64'(0));
        tick(2);
        check("arb_wp", 64'(wp), 64'(4));
        push_win(2'b01, 5'd4);
        op(1'b0, 1'b1, 1, "ret_back");
        check("ret_back_wp", 64'(wp), 64'(0));

        // Slow memory spill interrupted by reset during beat 2.
        for (int i = 0; i < 6; i++) begin
            push_win(2'b10, 5'(4 * i));
            op(1'b1, 1'b0, 1, "save_b");
        end
        ack_delay = 3;
        for (int k = 0; k < 2; k++) push_mem(1'b1, 16'(16'h0100 + k), 16'(16'h00A0 + k), 5'(k));
        save_req = 1'b1;
        tick(1);
        save_req = 1'b0;
        for (int g = 0; g < 40 && !(mem_req && mem_addr == 16'h0102); g++) tick(1);
        for (int s = 0; s < 3; s++) begin
            check("stall_req", 64'(mem_req), 64'(1));
            check("stall_we", 64'(mem_we), 64'(1));
            check("stall_addr", 64'(mem_addr), 64'(16'h0102));
            check("stall_wdata", 64'(mem_wdata), 64'(16'h00A2));
            check("stall_sel", 64'(rf_sel), 64'(2));
            check("stall_noack", 64'(mem_ack), 64'(0));
            if (s < 2) tick(1);
        end
        reset = 1'b1;
        #1;
        check("mid_rst_busy", 64'(busy), 64'(0));
        check("mid_rst_wp", 64'(wp), 64'(0));
        check("mid_rst_mem", 64'({mem_req, mem_we, mem_addr, mem_wdata}), 64'(0));
        check("mid_rst_rf", 64'({rf_we, rf_sel, rf_wdata}), 64'(0));
        check("mid_rst_flags", 64'({winAddSub, underflow_err, overflow_err}), 64'(0));
        tick(2);
        reset     = 1'b0;
        ack_delay = 0;
        tick(1);

        // spill_cnt must be back at 0 with res=1: a restore underflows.
        push_err(K_UNF, 5'd0);
        op(1'b0, 1'b1, 0, "unf_after_rst");
        check("wp_after_rst", 64'(wp), 64'(0));

        tick(3);
        check("sb_drained", 64'(exp_q.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/reg_window_ctrl.md
# reg_window_ctrl

Register-window spill/fill controller that sits directly upstream of the windowed 32-entry physical register file. It turns the processor's call (save) and return (restore) events into the 2-bit window-move command the register file consumes. It keeps a mirror of the window index and tracks how many windows are resident. On window overflow or underflow it stalls the core and moves the 4 non-shared registers of a window to or from a memory spill stack, using a req/ack handshake and a direct physical-register access port.

## Interface
Parameters:
- NUM_PHYS, 32, physical register count; window stride is fixed at 4 and a window spans 8 registers.
- MAX_RES, 7, maximum resident windows; equals NUM_PHYS/4 − 1.
- CNT_W, 12, width of the spilled-window counter.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- save_req  in  1  call event; sampled only when busy=0.
- restore_req  in  1  return event; sampled only when busy=0.
- busy  out  1  high whenever the FSM is not in IDLE; the core stalls on it.
- winAddSub  out  2  window-move command to the register file: 2'b10 = +4, 2'b01 = −4, 2'b00 = hold.
- wp  out  5  current window index, mirroring the register file's index.
- underflow_err  out  1  one-cycle pulse: restore requested with nothing left to restore.
- overflow_err  out  1  one-cycle pulse: spill counter saturated.
- sp_base  in  16  base word address of the spill stack.
- mem_req  out  1  memory beat request.
- mem_we  out  1  1 = write (spill), 0 = read (fill).
- mem_addr  out  16  beat word address.
- mem_wdata  out  16  spill data.
- mem_rdata  in  16  fill data; valid when mem_ack=1.
- mem_ack  in  1  beat completes in any cycle where mem_req & mem_ack.
- rf_sel  out  5  physical register index for spill/fill access.
- rf_rdata  in  16  combinational read of pr[rf_sel].
- rf_wdata  out  16  fill write data.
- rf_we  out  1  fill write strobe.

## Operation
State:
- wp (5b), res (3b, range 1..MAX_RES), spill_cnt (CNT_W), beat (2b).
- FSM states: IDLE, SPILL, ADV, FILL, RET.

Arbitration:
- save_req and restore_req high together in IDLE: save wins and restore is dropped.

Save (from IDLE):
- res < MAX_RES → go to ADV; res++.
- res == MAX_RES and spill_cnt at maximum → overflow_err pulse; stay in IDLE; no state change.
- res == MAX_RES otherwise → go to SPILL.
  - Spilled window base is ob = wp − 4·(res−1), mod 32.
  - Beat k (0..3): rf_sel = ob+k, mem_we=1, mem_addr = sp_base + 4·spill_cnt + k, mem_wdata = rf_rdata.
  - After beat 3 is acked: spill_cnt++ and go to ADV. res is unchanged.
- ADV: winAddSub=2'b10 for exactly one cycle, wp += 4 (mod 32), then IDLE.

Restore (from IDLE):
- res > 1 → go to RET; res−−.
- res == 1 and spill_cnt == 0 → underflow_err pulse; stay in IDLE.
- res == 1 and spill_cnt > 0 → go to FILL.
  - Beat k: mem_we=0, mem_addr = sp_base + 4·(spill_cnt−1) + k, rf_sel = wp−4+k (mod 32).
  - On the ack cycle: rf_we=1, rf_wdata = mem_rdata.
  - After beat 3: spill_cnt−−, then RET. res stays 1.
- RET: winAddSub=2'b01 for one cycle, wp −= 4 (mod 32), then IDLE.

Outputs:
- Outside SPILL/FILL: mem_req, rf_we = 0; mem_addr, rf_sel = 0.

## Timing
- Reset values: wp=0, res=1, spill_cnt=0, FSM=IDLE. All outputs are 0 (busy, winAddSub, mem_*, rf_*, err pulses).
- Non-spilling save or restore:
  - Request sampled at edge N.
  - busy=1 and winAddSub active during cycle N+1.
  - Back in IDLE with busy=0 at N+2.
- Handshake:
  - mem_req, mem_we, mem_addr, mem_wdata and rf_sel are held stable until the beat is acked.
  - The next beat may assert in the cycle after the ack.
  - Zero-wait memory gives 4 beat cycles + 1 ADV/RET cycle.
- Error pulses are high in the cycle after the request; busy stays 0.
- Requests arriving while busy=1 are ignored, not queued.
- wp wraps 28+4 → 0 and 0−4 → 28.
- Reset asserted mid-spill or mid-fill: immediate return to reset values. The in-flight beat is abandoned, and spill_cnt is not updated.

## Configuration
- WINCTRL_STATS_EN defined:
  - Adds outputs n_spills and n_fills (16 bits each, saturating).
  - Each increments by 1 on completion of its own sequence.
  - Both reset to 0.
- WINCTRL_STATS_EN undefined: the ports and counters do not exist; all other behaviour is identical.

## Test plan
- Reset, then idle 5 cycles → wp=0, busy=0, winAddSub=00, mem_req=0.
- Three saves spaced 3 cycles apart → each produces one cycle of winAddSub=10; wp reads 4, 8, 12; mem_req never asserts.
- Six saves, then a 7th, with sp_base=0x100, pr0..pr3 = 0xA0..0xA3, zero-wait ack:
  - Writes land at 0x100..0x103 with data 0xA0..0xA3.
  - Then winAddSub=10 fires and wp=28.
  - busy stays high for 5 cycles.
- From the previous state, 7 restores → six single-cycle RETs, then a FILL reading 0x100..0x103 into pr[wp−4..wp−1], then a RET; spill_cnt=0.
- Restore with res=1 and spill_cnt=0 → underflow_err pulses for 1 cycle; wp unchanged.
- Spill with mem_ack delayed 3 cycles per beat, reset asserted during beat 2 → mem outputs stable while waiting; after reset, all reset values and spill_cnt=0.
